// File: rtl/instruction_fetch_unit_if.sv
// Signal bundle shared by the fetch unit, the instruction memory and decode.
// The master side is the fetch unit; the slave side is its surroundings.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 8
);
  logic              redirect_valid;
  logic [31:0]       redirect_pc;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic [31:0]       out_pc_plus4;
  logic              out_fault;

  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, out_fault
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, out_fault
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues word reads to a 1-cycle instruction memory and
// queues the returned words for decode, with redirect flush and misaligned-target faults.
module instruction_fetch_unit #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  instruction_fetch_unit_if.master bus
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } entry_t;

  entry_t           queue_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      pc_q;
  logic             inflight_q;
  logic [31:0]      inflight_pc_q;
  logic             halt_q;

  logic             redirect;
  logic [31:0]      fetch_addr;
  logic             aligned;
  logic             pop;
  logic [CNT_W-1:0] occ_after;
  logic             infl_after;
  logic             credit_ok;
  logic             fetch_allowed;
  logic             issue;
  logic             fault_push;
  logic             resp_push;
  entry_t           resp_entry;
  entry_t           fault_entry;
  entry_t           head;
  logic [PTR_W-1:0] base_ptr;
  logic [PTR_W-1:0] fault_ptr;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [CNT_W-1:0] count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign redirect = bus.redirect_valid;

  // A fetch needs room for itself once this cycle's pop and any in-flight word land;
  // a redirect discards both, so it can always fetch.
  always_comb begin
    fetch_addr    = redirect ? bus.redirect_pc : pc_q;
    aligned       = (fetch_addr[1:0] == 2'b00);
    pop           = (count_q != '0) && bus.out_ready;
    occ_after     = redirect ? '0 : (count_q - CNT_W'(pop));
    infl_after    = inflight_q && !redirect;
    credit_ok     = ({1'b0, occ_after} + (CNT_W + 1)'(infl_after) + (CNT_W + 1)'(1)) <= DEPTH_C;
    fetch_allowed = (!halt_q || redirect) && credit_ok;
    issue         = fetch_allowed && aligned;
    fault_push    = fetch_allowed && !aligned;
    resp_push     = inflight_q && !redirect;
  end

  always_comb begin
    resp_entry  = '{instr: bus.imem_rdata, pc: inflight_pc_q, fault: 1'b0};
    fault_entry = '{instr: 32'h0, pc: fetch_addr, fault: 1'b1};
    base_ptr    = redirect ? '0 : wr_ptr_q;
    fault_ptr   = resp_push ? ptr_inc(base_ptr) : base_ptr;
    wr_ptr_d    = base_ptr;
    if (resp_push) begin
      wr_ptr_d = ptr_inc(wr_ptr_d);
    end
    if (fault_push) begin
      wr_ptr_d = ptr_inc(wr_ptr_d);
    end
    rd_ptr_d = redirect ? '0 : (pop ? ptr_inc(rd_ptr_q) : rd_ptr_q);
    count_d  = occ_after + CNT_W'(resp_push) + CNT_W'(fault_push);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      halt_q        <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      if (issue) begin
        pc_q          <= fetch_addr + 32'd4;
        inflight_pc_q <= fetch_addr;
      end
      inflight_q <= issue;
      halt_q     <= fault_push || (halt_q && !redirect);
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage needs no reset: count_q alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (resp_push) begin
      queue_q[base_ptr] <= resp_entry;
    end
    if (fault_push) begin
      queue_q[fault_ptr] <= fault_entry;
    end
  end

  assign head = queue_q[rd_ptr_q];

  // rst_n gates the request so memory sees nothing while the unit is held in reset.
  assign bus.imem_req     = issue && rst_n;
  assign bus.imem_addr    = fetch_addr[ADDR_W-1:0];
  assign bus.out_valid    = (count_q != '0);
  assign bus.out_instr    = bus.out_valid ? head.instr : 32'h0;
  assign bus.out_pc       = bus.out_valid ? head.pc : 32'h0;
  assign bus.out_pc_plus4 = bus.out_valid ? (head.pc + 32'd4) : 32'h0;
  assign bus.out_fault    = bus.out_valid && head.fault;

endmodule
